// File: rtl/writeback_commit.sv
// writeback_commit: registers a retiring bundle and drives register-file, CSR and commit ports
module writeback_commit #(
  parameter int LANES  = 2,
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*64-1:0]     in_pc,
  input  logic [LANES*32-1:0]     in_instr,
  input  logic [LANES-1:0]        in_regwrite,
  input  logic [LANES*REG_AW-1:0] in_dst,
  input  logic [LANES*XLEN-1:0]   in_regdata,
  input  logic [LANES-1:0]        in_csrwrite,
  input  logic [LANES*CSR_AW-1:0] in_csr_dst,
  input  logic [LANES*XLEN-1:0]   in_csrdata,
  input  logic [LANES-1:0]        in_skip,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*REG_AW-1:0] rf_waddr,
  output logic [LANES*XLEN-1:0]   rf_wdata,
  output logic                    csr_we,
  output logic [CSR_AW-1:0]       csr_waddr,
  output logic [XLEN-1:0]         csr_wdata,
  output logic [LANES-1:0]        commit_valid,
  output logic [LANES*64-1:0]     commit_pc,
  output logic [LANES*32-1:0]     commit_instr,
  output logic [LANES-1:0]        commit_skip,
  output logic [63:0]             instret
);
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FIRST, S_SECOND} state_t;
  state_t state, stateNext;
  // Internals are always two lanes wide; a missing lane 1 is held invalid.
  logic [1:0]          inLaneValid, inCsrWrite;
  logic [1:0]          laneValidQ, regWriteQ, csrWriteQ, skipQ;
  logic [127:0]        pcQ;
  logic [63:0]         instrQ;
  logic [2*REG_AW-1:0] dstQ;
  logic [2*XLEN-1:0]   regDataQ, csrDataQ;
  logic [2*CSR_AW-1:0] csrDstQ;
  logic [1:0]          commitV, rfRaw, rfWeV;
  logic                accept, dualCsr, csrSel;
  assign inLaneValid = 2'(in_lane_valid);
  assign inCsrWrite  = 2'(in_csrwrite);
  assign in_ready    = reset || state != S_FIRST;
  assign accept      = in_valid && in_ready;
  assign dualCsr     = LANES == 2 && &(inLaneValid & inCsrWrite);
  // Stage register: holds the bundle while it commits; stalled by in_ready in S_FIRST.
  always_ff @(posedge clk) begin
    if (accept) begin
      laneValidQ <= inLaneValid;
      regWriteQ  <= 2'(in_regwrite);
      csrWriteQ  <= inCsrWrite;
      skipQ      <= 2'(in_skip);
      pcQ        <= 128'(in_pc);
      instrQ     <= 64'(in_instr);
      dstQ       <= (2*REG_AW)'(in_dst);
      regDataQ   <= (2*XLEN)'(in_regdata);
      csrDstQ    <= (2*CSR_AW)'(in_csr_dst);
      csrDataQ   <= (2*XLEN)'(in_csrdata);
    end
  end
  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_EMPTY;
      instret <= '0;
    end else begin
      state   <= stateNext;
      instret <= instret + 64'(commitV[0]) + 64'(commitV[1]);
    end
  end
  // Next state: flush empties the stage; a dual-CSR bundle always spends two cycles.
  always_comb begin
    stateNext = S_EMPTY;
    if (!flush)
      stateNext = state == S_FIRST ? S_SECOND : accept ? (dualCsr ? S_FIRST : S_ONE) : S_EMPTY;
  end
  assign commitV = reset ? 2'b00 : laneValidQ & (state == S_ONE    ? 2'b11 :
                                                 state == S_FIRST  ? 2'b01 :
                                                 state == S_SECOND ? 2'b10 : 2'b00);
  assign rfRaw   = commitV & regWriteQ & {dstQ[2*REG_AW-1:REG_AW] != '0, dstQ[REG_AW-1:0] != '0};
  assign rfWeV   = {rfRaw[1], rfRaw[0] && !(rfRaw[1] && dstQ[REG_AW-1:0] == dstQ[2*REG_AW-1:REG_AW])};
  assign csrSel  = commitV[1] && csrWriteQ[1];
  assign csr_we    = csrSel || (commitV[0] && csrWriteQ[0]);
  assign csr_waddr = csrSel ? csrDstQ[2*CSR_AW-1:CSR_AW] : csrDstQ[CSR_AW-1:0];
  assign csr_wdata = csrSel ? csrDataQ[2*XLEN-1:XLEN] : csrDataQ[XLEN-1:0];
  assign rf_we        = rfWeV[LANES-1:0];
  assign rf_waddr     = dstQ[LANES*REG_AW-1:0];
  assign rf_wdata     = regDataQ[LANES*XLEN-1:0];
  assign commit_valid = commitV[LANES-1:0];
  assign commit_pc    = pcQ[LANES*64-1:0];
  assign commit_instr = instrQ[LANES*32-1:0];
  assign commit_skip  = skipQ[LANES-1:0];
endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit: table vectors, corner sequences and a queue-based reference model
module tb_writeback_commit;
  typedef struct packed {
    logic [1:0] lv, rw, cw, sk;
    logic [1:0][4:0]  dst;
    logic [1:0][63:0] rd, cd, pc;
    logic [1:0][31:0] ins;
    logic [1:0][11:0] ca;
  } bundle_t;
  typedef struct packed {
    bundle_t b;
    logic [1:0] mask;
  } ent_t;
  typedef struct packed {
    bundle_t b;
    logic [1:0] rfWe, cv;
    logic csrWe;
    logic [11:0] csrA;
    logic lane;
    logic [4:0] waddr;
    logic [63:0] wdata;
    logic [1:0] dInst;
  } vec_t;
  logic clk = 0, reset = 1, flush = 0, valid = 0;
  bundle_t b = '0;
  logic in_ready, csr_we;
  logic [1:0] rf_we, commit_valid, commit_skip;
  logic [9:0] rf_waddr;
  logic [127:0] rf_wdata, commit_pc;
  logic [63:0] commit_instr, csr_wdata, instret;
  logic [11:0] csr_waddr;
  int total = 0, bad = 0;
  ent_t q[$];
  logic [63:0] mInstret = 0;
  vec_t tbl[6];
  always #5 clk = ~clk;
  writeback_commit dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(valid), .in_ready(in_ready),
    .in_lane_valid(b.lv), .in_pc(b.pc), .in_instr(b.ins), .in_regwrite(b.rw), .in_dst(b.dst),
    .in_regdata(b.rd), .in_csrwrite(b.cw), .in_csr_dst(b.ca), .in_csrdata(b.cd), .in_skip(b.sk),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_skip(commit_skip), .instret(instret)
  );
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask
  function automatic bundle_t mk(input logic [1:0] lv, input logic [1:0] rw, input logic [1:0] cw,
                                 input logic [4:0] d0, input logic [4:0] d1,
                                 input logic [63:0] r0, input logic [63:0] r1,
                                 input logic [11:0] a0, input logic [11:0] a1);
    bundle_t x = '0;
    x.lv = lv; x.rw = rw; x.cw = cw; x.sk = 2'b10;
    x.dst[0] = d0; x.dst[1] = d1; x.rd[0] = r0; x.rd[1] = r1;
    x.ca[0] = a0; x.ca[1] = a1;
    x.cd[0] = 64'(a0) + 64'h1000; x.cd[1] = 64'(a1) + 64'h2000;
    x.pc[0] = 64'h80000000; x.pc[1] = 64'h80000004;
    x.ins[0] = 32'h00000013; x.ins[1] = 32'h00100093;
    return x;
  endfunction
  // Compare every output against what the model says the front of the commit queue should produce.
  task automatic checkAll();
    logic [1:0] cvE = 0, rwE = 0;
    logic csrE = 0;
    logic [11:0] caE = 0;
    logic [63:0] cdE = 0;
    ent_t e = '0;
    if (!reset && q.size() > 0) begin
      e = q[0];
      cvE = e.mask & e.b.lv;
      for (int i = 0; i < 2; i++) begin
        if (cvE[i] && e.b.rw[i] && e.b.dst[i] != 0) rwE[i] = 1;
        if (cvE[i] && e.b.cw[i]) begin csrE = 1; caE = e.b.ca[i]; cdE = e.b.cd[i]; end
      end
      if (rwE == 2'b11 && e.b.dst[0] == e.b.dst[1]) rwE[0] = 0;
    end
    chk("commit_valid", 128'(commit_valid), 128'(cvE));
    chk("rf_we", 128'(rf_we), 128'(rwE));
    chk("csr_we", 128'(csr_we), 128'(csrE));
    chk("in_ready", 128'(in_ready), 128'(reset || q.size() != 2));
    chk("instret", 128'(instret), 128'(mInstret));
    if (csrE) begin
      chk("csr_waddr", 128'(csr_waddr), 128'(caE));
      chk("csr_wdata", 128'(csr_wdata), 128'(cdE));
    end
    for (int i = 0; i < 2; i++) begin
      if (rwE[i]) begin
        chk("rf_waddr", 128'(rf_waddr[i*5 +: 5]), 128'(e.b.dst[i]));
        chk("rf_wdata", 128'(rf_wdata[i*64 +: 64]), 128'(e.b.rd[i]));
      end
      if (cvE[i]) begin
        chk("commit_pc", 128'(commit_pc[i*64 +: 64]), 128'(e.b.pc[i]));
        chk("commit_instr", 128'(commit_instr[i*32 +: 32]), 128'(e.b.ins[i]));
        chk("commit_skip", 128'(commit_skip[i]), 128'(e.b.sk[i]));
      end
    end
  endtask
  // One clock: advance the model with the inputs seen at the edge, then check at the falling edge.
  task automatic tick();
    logic acc;
    acc = valid && q.size() != 2;
    @(posedge clk);
    if (q.size() > 0) begin
      mInstret += 64'($countones(q[0].mask & q[0].b.lv));
      void'(q.pop_front());
    end
    if (reset || flush) q.delete();
    if (reset) mInstret = 0;
    if (acc && !flush && !reset) begin
      if (&(b.lv & b.cw)) begin
        q.push_back('{b, 2'b01});
        q.push_back('{b, 2'b10});
      end else q.push_back('{b, 2'b11});
    end
    @(negedge clk);
    checkAll();
  endtask
  initial begin
    logic [63:0] base;
    tbl[0] = '{mk(2'b01, 2'b01, 2'b00, 5, 0, 64'h1234, 0, 0, 0), 2'b01, 2'b01, 1'b0, 12'h0, 1'b0, 5'd5, 64'h1234, 2'd1};
    tbl[1] = '{mk(2'b01, 2'b01, 2'b00, 0, 0, 64'h55, 0, 0, 0), 2'b00, 2'b01, 1'b0, 12'h0, 1'b0, 5'd0, 64'h0, 2'd1};
    tbl[2] = '{mk(2'b11, 2'b11, 2'b00, 7, 7, 64'h1, 64'h2, 0, 0), 2'b10, 2'b11, 1'b0, 12'h0, 1'b1, 5'd7, 64'h2, 2'd2};
    tbl[3] = '{mk(2'b01, 2'b11, 2'b10, 3, 4, 64'h33, 64'h44, 0, 12'h341), 2'b01, 2'b01, 1'b0, 12'h0, 1'b0, 5'd3, 64'h33, 2'd1};
    tbl[4] = '{mk(2'b11, 2'b00, 2'b10, 1, 2, 0, 0, 12'h300, 12'h341), 2'b00, 2'b11, 1'b1, 12'h341, 1'b0, 5'd0, 64'h0, 2'd2};
    tbl[5] = '{mk(2'b11, 2'b11, 2'b00, 1, 2, 64'hA1, 64'hB2, 0, 0), 2'b11, 2'b11, 1'b0, 12'h0, 1'b0, 5'd1, 64'hA1, 2'd2};
    @(negedge clk);
    tick();
    chk("reset idle", 128'({rf_we, csr_we, commit_valid, in_ready}), 128'(6'b000001));
    chk("reset instret", 128'(instret), 128'(0));
    reset = 0;
    tick();
    chk("after reset idle", 128'({rf_we, csr_we, commit_valid}), 128'(0));
    for (int i = 0; i < 6; i++) begin
      base = mInstret;
      b = tbl[i].b; valid = 1;
      tick();
      valid = 0;
      chk($sformatf("tbl%0d rf_we", i), 128'(rf_we), 128'(tbl[i].rfWe));
      chk($sformatf("tbl%0d commit_valid", i), 128'(commit_valid), 128'(tbl[i].cv));
      chk($sformatf("tbl%0d csr_we", i), 128'(csr_we), 128'(tbl[i].csrWe));
      if (tbl[i].csrWe) chk($sformatf("tbl%0d csr_waddr", i), 128'(csr_waddr), 128'(tbl[i].csrA));
      if (tbl[i].rfWe[tbl[i].lane]) begin
        chk($sformatf("tbl%0d rf_waddr", i), 128'(rf_waddr[tbl[i].lane*5 +: 5]), 128'(tbl[i].waddr));
        chk($sformatf("tbl%0d rf_wdata", i), 128'(rf_wdata[tbl[i].lane*64 +: 64]), 128'(tbl[i].wdata));
      end
      tick();
      chk($sformatf("tbl%0d instret", i), 128'(instret), 128'(base + 64'(tbl[i].dInst)));
    end
    base = mInstret;
    b = mk(2'b11, 2'b00, 2'b11, 0, 0, 0, 0, 12'h300, 12'h305);
    b.cd[0] = 64'hA; b.cd[1] = 64'hB; valid = 1;
    tick();
    valid = 0;
    chk("dual c1", 128'({csr_we, csr_waddr, csr_wdata[7:0], commit_valid, in_ready}), 128'({1'b1, 12'h300, 8'hA, 2'b01, 1'b0}));
    tick();
    chk("dual c2", 128'({csr_we, csr_waddr, csr_wdata[7:0], commit_valid, in_ready}), 128'({1'b1, 12'h305, 8'hB, 2'b10, 1'b1}));
    tick();
    chk("dual instret", 128'(instret), 128'(base + 2));
    base = mInstret; valid = 1;
    tick();
    valid = 0; flush = 1;
    chk("flush first", 128'(commit_valid), 128'(2'b01));
    tick();
    flush = 0;
    chk("flush idle", 128'({commit_valid, csr_we, in_ready}), 128'(4'b0001));
    chk("flush instret", 128'(instret), 128'(base + 1));
    tick();
    chk("flush no lane1", 128'(commit_valid), 128'(0));
    valid = 1;
    for (int i = 0; i < 4; i++) begin
      b = mk(2'b01, 2'b01, 2'b01, 5'(i + 8), 0, 64'(i), 0, 12'(12'h340 + i), 0);
      tick();
      chk("b2b ready", 128'(in_ready), 128'(1));
      chk("b2b commit", 128'({commit_valid, csr_waddr}), 128'({2'b01, 12'(12'h340 + i)}));
    end
    reset = 1;
    tick();
    chk("mid reset idle", 128'({rf_we, csr_we, commit_valid, in_ready}), 128'(6'b000001));
    chk("mid reset instret", 128'(instret), 128'(0));
    reset = 0; valid = 0;
    tick();
    chk("mid reset after", 128'(commit_valid), 128'(0));
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++) begin
        b.dst[i] = 5'($urandom_range(0, 3));
        b.rd[i] = {$urandom, $urandom};
        b.cd[i] = {$urandom, $urandom};
        b.pc[i] = {$urandom, $urandom};
        b.ins[i] = $urandom;
        b.ca[i] = 12'($urandom);
      end
      b.lv = 2'($urandom); b.rw = 2'($urandom); b.cw = 2'($urandom); b.sk = 2'($urandom);
      valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 59) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
